// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: pipeline port P has priority, the multi-cycle port S is
// buffered in a small FIFO, and a starvation guard forces S through after STARVE_MAX P wins.
module reg_wb_arbiter #(
   parameter int              DATA_W     = 16,
   parameter int              ADDR_W     = 3,
   parameter int              OP_W       = 3,
   parameter int              FIFO_DEPTH = 2,
   parameter int              STARVE_MAX = 3,
   parameter logic [OP_W-1:0] REG_OP_NOP = '0
) (
   input  logic              clk_50MHz,
   input  logic              rst,
   input  logic [OP_W-1:0]   p_op,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_data,
   output logic              p_stall,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [OP_W-1:0]   s_op,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_busy,
   output logic [OP_W-1:0]   reg_op,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SC_W  = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_P,
      GNT_S
   } grant_e;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [SC_W-1:0]  starve_q, starve_d;
   wb_req_t          mem_q [FIFO_DEPTH];

   wb_req_t head;
   wb_req_t s_in;
   grant_e  grant;
   logic    p_req, s_req, full, force_s, push, pop;

   always_comb begin
      // NOTE: every variable gets a default first, so no branch can leave one unassigned (latch).
      head     = mem_q[rd_ptr_q];
      s_in     = '{op: s_op, addr: s_addr, data: s_data};
      p_req    = (p_op != REG_OP_NOP);
      s_req    = (count_q != '0);
      full     = (count_q == CNT_W'(FIFO_DEPTH));
      force_s  = s_req && (starve_q == SC_W'(STARVE_MAX));
      grant    = GNT_NONE;
      p_stall  = 1'b0;
      s_ready  = 1'b0;
      s_busy   = 1'b0;
      reg_op   = REG_OP_NOP;
      wb_addr  = '0;
      wb_data  = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      starve_d = starve_q;

      // Reset is asynchronous, so the outputs are gated by rst directly, not only via the flops.
      if (rst) begin
         s_ready = !full;
         s_busy  = s_req;
         if (force_s) begin
            grant   = GNT_S;
            p_stall = p_req;
         end else if (p_req) begin
            grant = GNT_P;
         end else if (s_req) begin
            grant = GNT_S;
         end
      end

      unique case (grant)
         GNT_P: begin
            reg_op  = p_op;
            wb_addr = p_addr;
            wb_data = p_data;
         end
         GNT_S: begin
            reg_op  = head.op;
            wb_addr = head.addr;
            wb_data = head.data;
         end
         default: ;
      endcase

      // NOP requests on S complete the handshake but never occupy a slot.
      push = s_valid && s_ready && (s_op != REG_OP_NOP);
      pop  = (grant == GNT_S);

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (grant == GNT_P && s_req) begin
         if (starve_q != SC_W'(STARVE_MAX)) starve_d = starve_q + SC_W'(1);
      end else if (grant == GNT_S || !s_req) begin
         starve_d = '0;
      end
   end

   always_ff @(posedge clk_50MHz or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
      end
   end

   // NOTE: the storage array is not reset; the count and pointers alone decide which entries are live.
   always_ff @(posedge clk_50MHz) begin
      if (push) mem_q[wr_ptr_q] <= s_in;
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios feed an expected-commit queue
// that a monitor drains whenever the arbiter drives a write.
module tb_reg_wb_arbiter;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_REG = 3'd1;
   localparam logic [2:0] OP_T   = 3'd2;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic        clk_50MHz;
   logic        rst;
   logic [2:0]  p_op, p_addr, s_op, s_addr, reg_op, wb_addr;
   logic [15:0] p_data, s_data, wb_data;
   logic        p_stall, s_valid, s_ready, s_busy;

   exp_t        exp_q[$];
   logic [15:0] regs [8];
   int          vectors = 0;
   int          miscompares = 0;

   reg_wb_arbiter dut (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .p_op      (p_op),
      .p_addr    (p_addr),
      .p_data    (p_data),
      .p_stall   (p_stall),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_op      (s_op),
      .s_addr    (s_addr),
      .s_data    (s_data),
      .s_busy    (s_busy),
      .reg_op    (reg_op),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data)
   );

   initial clk_50MHz = 1'b0;
   always #10 clk_50MHz = ~clk_50MHz;

   // Every write the arbiter drives must be the next one the bench expects.
   always @(negedge clk_50MHz) begin
      if (rst === 1'b1 && reg_op !== OP_NOP) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got op=%0d addr=%0d data=%h, required no write",
                     reg_op, wb_addr, wb_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({reg_op, wb_addr, wb_data} !== {e.op, e.addr, e.data}) begin
               miscompares++;
               $display("FAIL commit: got op=%0d addr=%0d data=%h, required op=%0d addr=%0d data=%h",
                        reg_op, wb_addr, wb_data, e.op, e.addr, e.data);
            end
         end
      end
   end

   always @(posedge clk_50MHz) begin
      if (rst === 1'b1 && reg_op !== OP_NOP) regs[wb_addr] <= wb_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_50MHz);
      #1;
   endtask

   task automatic exp_push(input logic [2:0] op, input logic [2:0] addr, input logic [15:0] data);
      exp_t e;
      e.op   = op;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic drive_p(input logic [2:0] op, input logic [2:0] addr, input logic [15:0] data);
      p_op   = op;
      p_addr = addr;
      p_data = data;
   endtask

   task automatic drive_s(input logic v, input logic [2:0] op, input logic [2:0] addr,
                          input logic [15:0] data);
      s_valid = v;
      s_op    = op;
      s_addr  = addr;
      s_data  = data;
   endtask

   task automatic check_drained(input string name);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_drained: %0d expected writes never appeared, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive_p(OP_REG, 3'd1, 16'hDEAD);
      drive_s(1'b1, OP_REG, 3'd2, 16'hCAFE);
      #5;
      vectors++;
      if ({reg_op, wb_addr, wb_data, p_stall, s_ready, s_busy} !== {OP_NOP, 3'd0, 16'h0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_outputs: got op=%0d addr=%0d data=%h stall=%b ready=%b busy=%b, required all zero",
                  reg_op, wb_addr, wb_data, p_stall, s_ready, s_busy);
      end
      drive_p(OP_NOP, 3'd0, 16'h0);
      drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
      repeat (2) @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      rst = 1'b1;
      tick();
      @(negedge clk_50MHz);
      vectors++;
      if ({reg_op, s_ready, s_busy, p_stall} !== {OP_NOP, 3'b100}) begin
         miscompares++;
         $display("FAIL reset_release: got op=%0d ready=%b busy=%b stall=%b, required op=0 ready=1 busy=0 stall=0",
                  reg_op, s_ready, s_busy, p_stall);
      end
      tick();
   endtask

   task automatic test_p_only();
      exp_push(OP_REG, 3'd3, 16'h1234);
      drive_p(OP_REG, 3'd3, 16'h1234);
      @(negedge clk_50MHz);
      vectors++;
      if (p_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL p_only_stall: got %b, required 0", p_stall);
      end
      tick();
      drive_p(OP_NOP, 3'd0, 16'h0);
      check_drained("p_only");
   endtask

   task automatic test_s_only();
      exp_push(OP_REG, 3'd5, 16'hBEEF);
      drive_s(1'b1, OP_REG, 3'd5, 16'hBEEF);
      @(negedge clk_50MHz);
      vectors++;
      if ({s_ready, reg_op} !== {1'b1, OP_NOP}) begin
         miscompares++;
         $display("FAIL s_accept_no_bypass: got ready=%b op=%0d, required ready=1 op=0", s_ready, reg_op);
      end
      tick();
      drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
      @(negedge clk_50MHz);
      vectors++;
      if (s_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL s_busy_set: got %b, required 1", s_busy);
      end
      tick();
      @(negedge clk_50MHz);
      vectors++;
      if (s_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL s_busy_clear: got %b, required 0", s_busy);
      end
      // A NOP on S is accepted but must leave nothing behind.
      tick();
      drive_s(1'b1, OP_NOP, 3'd6, 16'h5555);
      tick();
      drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
      @(negedge clk_50MHz);
      vectors++;
      if (s_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL s_nop_dropped: got busy=%b, required 0", s_busy);
      end
      // Non-GPR ops pass straight through with their address.
      tick();
      exp_push(OP_T, 3'd7, 16'hA5A5);
      drive_s(1'b1, OP_T, 3'd7, 16'hA5A5);
      tick();
      drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
      tick();
      check_drained("s_only");
   endtask

   task automatic test_backpressure();
      exp_push(OP_REG, 3'd1, 16'h1000);
      exp_push(OP_REG, 3'd1, 16'h1001);
      exp_push(OP_REG, 3'd1, 16'h1002);
      exp_push(OP_REG, 3'd4, 16'hA000);
      exp_push(OP_REG, 3'd5, 16'hB000);
      exp_push(OP_REG, 3'd6, 16'hC000);
      // P busy for three cycles while S offers A, B, then C (which must wait).
      for (int c = 0; c < 5; c++) begin
         logic exp_ready;
         if (c < 3) drive_p(OP_REG, 3'd1, 16'h1000 + 16'(c));
         else       drive_p(OP_NOP, 3'd0, 16'h0);
         case (c)
            0:       drive_s(1'b1, OP_REG, 3'd4, 16'hA000);
            1:       drive_s(1'b1, OP_REG, 3'd5, 16'hB000);
            default: drive_s(1'b1, OP_REG, 3'd6, 16'hC000);
         endcase
         exp_ready = (c == 0 || c == 1 || c == 4);
         @(negedge clk_50MHz);
         vectors++;
         if (s_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL backpressure_ready[%0d]: got %b, required %b", c, s_ready, exp_ready);
         end
         tick();
      end
      drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
      @(negedge clk_50MHz);
      vectors++;
      if (s_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure_busy: got %b, required 1", s_busy);
      end
      tick();
      tick();
      check_drained("backpressure");
   endtask

   task automatic test_starvation();
      logic [5:0] stall_exp = 6'b010000;
      int         p_idx [6] = '{0, 1, 2, 3, 4, 4};
      for (int i = 0; i < 4; i++) exp_push(OP_REG, 3'd2, 16'h2000 + 16'(i));
      exp_push(OP_REG, 3'd7, 16'h7777);
      exp_push(OP_REG, 3'd2, 16'h2004);
      for (int c = 0; c < 6; c++) begin
         drive_p(OP_REG, 3'd2, 16'h2000 + 16'(p_idx[c]));
         if (c == 0) drive_s(1'b1, OP_REG, 3'd7, 16'h7777);
         else        drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
         @(negedge clk_50MHz);
         vectors++;
         if (p_stall !== stall_exp[c]) begin
            miscompares++;
            $display("FAIL starvation_stall[%0d]: got %b, required %b", c, p_stall, stall_exp[c]);
         end
         tick();
      end
      drive_p(OP_NOP, 3'd0, 16'h0);
      tick();
      check_drained("starvation");
   endtask

   task automatic test_ordering();
      exp_push(OP_REG, 3'd2, 16'h0002);
      exp_push(OP_REG, 3'd2, 16'h0001);
      drive_s(1'b1, OP_REG, 3'd2, 16'h0001);
      tick();
      drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
      drive_p(OP_REG, 3'd2, 16'h0002);
      tick();
      drive_p(OP_NOP, 3'd0, 16'h0);
      tick();
      tick();
      vectors++;
      if (regs[2] !== 16'h0001) begin
         miscompares++;
         $display("FAIL ordering_r2: got %h, required 0001", regs[2]);
      end
      check_drained("ordering");
   endtask

   task automatic test_reset_mid();
      exp_push(OP_REG, 3'd1, 16'h3000);
      exp_push(OP_REG, 3'd1, 16'h3001);
      drive_p(OP_REG, 3'd1, 16'h3000);
      drive_s(1'b1, OP_REG, 3'd4, 16'h4444);
      tick();
      drive_p(OP_REG, 3'd1, 16'h3001);
      drive_s(1'b1, OP_REG, 3'd5, 16'h5555);
      tick();
      drive_p(OP_REG, 3'd1, 16'h3002);
      drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
      rst = 1'b0;
      #1;
      vectors++;
      if ({reg_op, wb_addr, wb_data, p_stall, s_ready, s_busy} !== {OP_NOP, 3'd0, 16'h0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got op=%0d addr=%0d data=%h stall=%b ready=%b busy=%b, required all zero",
                  reg_op, wb_addr, wb_data, p_stall, s_ready, s_busy);
      end
      drive_p(OP_NOP, 3'd0, 16'h0);
      @(negedge clk_50MHz);
      rst = 1'b1;
      tick();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_50MHz);
         vectors++;
         if ({s_busy, s_ready, reg_op} !== {2'b01, OP_NOP}) begin
            miscompares++;
            $display("FAIL reset_mid_after[%0d]: got busy=%b ready=%b op=%0d, required busy=0 ready=1 op=0",
                     c, s_busy, s_ready, reg_op);
         end
         tick();
      end
      check_drained("reset_mid");
   endtask

   initial begin
      rst = 1'b0;
      drive_p(OP_NOP, 3'd0, 16'h0);
      drive_s(1'b0, OP_NOP, 3'd0, 16'h0);
      test_reset();
      test_p_only();
      test_s_only();
      test_backpressure();
      test_starvation();
      test_ordering();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
